// File: rtl/seq_alu.sv
// Registered sequential ALU: single-cycle ops plus iterative shift-add multiply and
// restoring divide, behind a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       Alu_Op,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_hi,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  typedef enum logic [2:0] {IDLE, EXEC1, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] r_q, s_q;
  // mul: acc = running high half, lo = multiplier shifting out / product low half
  // div: acc = partial remainder, lo = dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d, yh_q, yh_d;
  logic [3:0]       fl_q, fl_d;  // {N,Z,C,V}

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] ey;
  logic             ec, ev;

  always_comb begin
    ext = '0;
    ey  = '0;
    ec  = 1'b0;
    ev  = 1'b0;
    case (op_q)
      4'h0: ey = s_q;
      4'h1: ey = r_q;
      4'h2: begin
        ext = {1'b0, s_q} + ONE_X;
        ey  = ext[MSB:0];
        ec  = ext[WIDTH];
        ev  = (s_q == {1'b0, {MSB{1'b1}}});
      end
      4'h3: begin
        ext = {1'b0, s_q} - ONE_X;
        ey  = ext[MSB:0];
        ec  = ext[WIDTH];
        ev  = (s_q == {1'b1, {MSB{1'b0}}});
      end
      4'h4: begin
        ext = {1'b0, r_q} + {1'b0, s_q};
        ey  = ext[MSB:0];
        ec  = ext[WIDTH];
        ev  = (r_q[MSB] == s_q[MSB]) && (ext[MSB] != r_q[MSB]);
      end
      4'h5: begin
        ext = {1'b0, r_q} - {1'b0, s_q};
        ey  = ext[MSB:0];
        ec  = ext[WIDTH];
        ev  = (r_q[MSB] != s_q[MSB]) && (ext[MSB] != r_q[MSB]);
      end
      4'h6: begin
        ey = {1'b0, s_q[MSB:1]};
        ec = s_q[0];
      end
      4'h7: begin
        ey = {s_q[MSB-1:0], 1'b0};
        ec = s_q[MSB];
      end
      4'h8: ey = r_q & s_q;
      4'h9: ey = r_q | s_q;
      4'hA: ey = r_q ^ s_q;
      4'hB: ey = ~s_q;
      4'hC: begin
        ext = -{1'b0, s_q};
        ey  = ext[MSB:0];
        ec  = ext[WIDTH];
        ev  = s_q[MSB] && ext[MSB];
      end
      4'hF: begin
        ey = {s_q[MSB], s_q[MSB:1]};
        ec = s_q[0];
      end
      default: ey = '0;
    endcase
  end

  logic [WIDTH:0]   madd, rsh, dsub;
  logic [WIDTH-1:0] mhi, mlo, rem, quo;
  logic             last;

  always_comb begin
    madd = {1'b0, acc_q} + (lo_q[0] ? {1'b0, r_q} : '0);
    mhi  = madd[WIDTH:1];
    mlo  = {madd[0], lo_q[MSB:1]};
    rsh  = {acc_q, lo_q[MSB]};
    dsub = rsh - {1'b0, s_q};
    // no borrow means the shifted remainder was >= divisor: keep the difference
    rem  = dsub[WIDTH] ? rsh[MSB:0] : dsub[MSB:0];
    quo  = {lo_q[MSB-1:0], ~dsub[WIDTH]};
    last = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    yh_d    = yh_q;
    fl_d    = fl_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (Alu_Op == 4'hD) ? MUL : (Alu_Op == 4'hE) ? DIV : EXEC1;
        acc_d   = '0;
        cnt_d   = '0;
        lo_d    = (Alu_Op == 4'hD) ? S : R;
      end
      EXEC1: begin
        state_d = DONE;
        y_d     = ey;
        yh_d    = '0;
        fl_d    = {ey[MSB], ey == '0, ec, ev};
      end
      MUL: begin
        acc_d = mhi;
        lo_d  = mlo;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          y_d     = mlo;
          yh_d    = mhi;
          fl_d    = {mlo[MSB], {mhi, mlo} == '0, mhi != '0, 1'b0};
        end
      end
      DIV: begin
        if (s_q == '0) begin
          state_d = DONE;
          y_d     = '1;
          yh_d    = r_q;
          fl_d    = 4'b1010;
        end else begin
          acc_d = rem;
          lo_d  = quo;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = DONE;
            y_d     = quo;
            yh_d    = rem;
            fl_d    = {quo[MSB], quo == '0, 2'b00};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      yh_q    <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yh_q    <= yh_d;
      fl_q    <= fl_d;
      if (state_q == IDLE && start) begin
        op_q <= Alu_Op;
        r_q  <= R;
        s_q  <= S;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign Y            = y_q;
  assign Y_hi         = yh_q;
  assign {N, Z, C, V} = fl_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: 16-bit and 8-bit instances, directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start16, start8;
  logic [3:0]  op16, op8;
  logic [15:0] r16, s16, y16, yh16;
  logic [7:0]  r8, s8, y8, yh8;
  logic        busy16, done16, n16, z16, c16, v16;
  logic        busy8, done8, n8, z8, c8, v8;

  int checks = 0;
  int failures = 0;

  seq_alu #(.WIDTH(16), .CNT_W(5)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .Alu_Op(op16), .R(r16), .S(s16),
    .busy(busy16), .done(done16), .Y(y16), .Y_hi(yh16), .N(n16), .Z(z16), .C(c16), .V(v16));

  seq_alu #(.WIDTH(8), .CNT_W(5)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .Alu_Op(op8), .R(r8), .S(s8),
    .busy(busy8), .done(done8), .Y(y8), .Y_hi(yh8), .N(n8), .Z(z8), .C(c8), .V(v8));

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] yh;
    logic        n, z, c, v;
  } res_t;

  function automatic res_t model(int w, logic [3:0] op, logic [15:0] ri, logic [15:0] si);
    longint unsigned mask, r, s, t, p, sb;
    res_t o;
    mask = (64'd1 << w) - 1;
    sb   = 64'd1 << (w - 1);
    r = {48'd0, ri} & mask;
    s = {48'd0, si} & mask;
    o = '0;
    t = 0;
    p = 0;
    case (op)
      4'd0: t = s;
      4'd1: t = r;
      4'd2: begin t = s + 1; o.c = (t > mask); o.v = (s == sb - 1); end
      4'd3: begin t = s - 1; o.c = (s == 0);   o.v = (s == sb);     end
      4'd4: begin t = r + s; o.c = (t > mask); o.v = ((r & sb) == (s & sb)) && ((t & sb) != (r & sb)); end
      4'd5: begin t = r - s; o.c = (r < s);    o.v = ((r & sb) != (s & sb)) && ((t & sb) != (r & sb)); end
      4'd6: begin t = s >> 1; o.c = (s & 1) != 0; end
      4'd7: begin t = s << 1; o.c = (s & sb) != 0; end
      4'd8: t = r & s;
      4'd9: t = r | s;
      4'd10: t = r ^ s;
      4'd11: t = ~s;
      4'd12: begin t = 0 - s; o.c = (s != 0); o.v = ((s & sb) != 0) && ((t & sb) != 0); end
      4'd13: begin p = r * s; t = p; o.yh = 16'((p >> w) & mask); end
      4'd14: if (s == 0) begin t = mask; o.yh = 16'(r); o.c = 1'b1; end
             else begin t = r / s; o.yh = 16'(r % s); end
      default: begin t = (s >> 1) | (s & sb); o.c = (s & 1) != 0; end
    endcase
    o.y = 16'(t & mask);
    o.n = (t & sb) != 0;
    o.z = (t & mask) == 0;
    if (op == 4'd13) begin
      o.z = (p == 0);
      o.c = (o.yh != 0);
    end
    return o;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t observe(bit w8);
    res_t o;
    if (w8) o = '{y: {8'd0, y8}, yh: {8'd0, yh8}, n: n8, z: z8, c: c8, v: v8};
    else    o = '{y: y16, yh: yh16, n: n16, z: z16, c: c16, v: v16};
    return o;
  endfunction

  task automatic drive(bit w8, bit st, logic [3:0] op, logic [15:0] r, logic [15:0] s);
    if (w8) begin start8 = st; op8 = op; r8 = r[7:0]; s8 = s[7:0]; end
    else    begin start16 = st; op16 = op; r16 = r; s16 = s; end
  endtask

  // Issue one op, then scramble inputs while busy (optionally pulsing start).
  task automatic run_op(string tag, bit w8, logic [3:0] op, logic [15:0] r, logic [15:0] s,
                        int exp_lat, bit pulse);
    res_t e, prev, o;
    int   lat, bad;
    e    = model(w8 ? 8 : 16, op, r, s);
    prev = observe(w8);
    lat  = -1;
    bad  = 0;
    @(negedge clk);
    drive(w8, 1'b1, op, r, s);
    for (int k = 1; k <= exp_lat + 3; k++) begin
      @(negedge clk);
      o = observe(w8);
      if ((w8 ? busy8 : busy16) !== 1'b1) bad++;
      if ((w8 ? done8 : done16) === 1'b1) begin
        lat = k;
        drive(w8, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
        break;
      end
      if (o !== prev) bad++;
      drive(w8, pulse ? 1'($urandom) : 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
    end
    if (lat < 0) drive(w8, 1'b0, 4'd0, 16'd0, 16'd0);
    o = observe(w8);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy/hold"}, 64'(bad), 64'd0);
    chk({tag, " Y"}, 64'(o.y), 64'(e.y));
    chk({tag, " Y_hi"}, 64'(o.yh), 64'(e.yh));
    chk({tag, " NZCV"}, 64'({o.n, o.z, o.c, o.v}), 64'({e.n, e.z, e.c, e.v}));
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] tab [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    int sel = $urandom_range(0, 7);
    return (sel < 5) ? tab[sel] : 16'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int   dmis, ndone;
    res_t o;
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 4'hD, 16'hFFFF, 16'h0003);
    drive(1'b1, 1'b1, 4'hD, 16'h00FF, 16'h00FF);

    // reset held with start asserted: everything stays zero
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset16", 64'({busy16, done16, y16, yh16, n16, z16, c16, v16}), 64'd0);
      chk("reset8", 64'({busy8, done8, y8, yh8, n8, z8, c8, v8}), 64'd0);
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    reset_n = 1'b1;

    run_op("add_ovf", 1'b0, 4'h4, 16'h7FFF, 16'h0001, 2, 1'b0);
    chk("add_ovf const", 64'({y16, n16, z16, c16, v16}), 64'({16'h8000, 4'b1001}));
    run_op("sub_borrow", 1'b0, 4'h5, 16'h0000, 16'h0001, 2, 1'b0);
    chk("sub_borrow const", 64'({y16, c16, v16}), 64'({16'hFFFF, 2'b10}));
    run_op("inc_ovf", 1'b0, 4'h2, 16'h0000, 16'h7FFF, 2, 1'b0);
    run_op("dec_ovf", 1'b0, 4'h3, 16'h0000, 16'h8000, 2, 1'b0);
    run_op("neg_min", 1'b0, 4'hC, 16'h0000, 16'h8000, 2, 1'b0);
    run_op("asr", 1'b0, 4'hF, 16'h0000, 16'h8001, 2, 1'b0);

    run_op("mul", 1'b0, 4'hD, 16'hFFFF, 16'h0003, 17, 1'b1);
    chk("mul const", 64'({yh16, y16, c16}), 64'({16'h0002, 16'hFFFD, 1'b1}));
    run_op("div", 1'b0, 4'hE, 16'd1000, 16'd7, 17, 1'b1);
    chk("div const", 64'({y16, yh16}), 64'({16'd142, 16'd6}));
    run_op("div0", 1'b0, 4'hE, 16'h1234, 16'h0000, 2, 1'b0);
    chk("div0 const", 64'({y16, yh16, c16}), 64'({16'hFFFF, 16'h1234, 1'b1}));

    // reset in the middle of a multiply
    @(negedge clk);
    drive(1'b0, 1'b1, 4'hD, 16'hFFFF, 16'h0003);
    ndone = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
      if (done16 === 1'b1) ndone++;
    end
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done16 === 1'b1) ndone++;
    end
    chk("midreset done", 64'(ndone), 64'd0);
    chk("midreset outs", 64'({busy16, done16, y16, yh16, n16, z16, c16, v16}), 64'd0);
    reset_n = 1'b1;
    run_op("after_reset", 1'b0, 4'h1, 16'h00A5, 16'h5A5A, 2, 1'b0);
    chk("after_reset const", 64'(y16), 64'h00A5);

    // start held high: one op every three cycles
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h2, 16'h0000, 16'hFFFF);
    dmis = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done16 !== ((k % 3) == 2)) dmis++;
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    chk("b2b cadence", 64'(dmis), 64'd0);
    chk("b2b result", 64'({y16, z16, c16}), 64'({16'h0000, 2'b11}));
    @(negedge clk);

    run_op("mul8", 1'b1, 4'hD, 16'h00FF, 16'h00FF, 9, 1'b1);
    o = observe(1'b1);
    chk("mul8 const", 64'({o.yh[7:0], o.y[7:0]}), 64'h0000_0000_0000_FE01);
    run_op("div8", 1'b1, 4'hE, 16'h00C8, 16'h0009, 9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [15:0] r, s;
      bit          w8;
      int          lat, w;
      w8 = (i % 4) == 3;
      w  = w8 ? 8 : 16;
      op = 4'($urandom);
      r  = pick_operand();
      s  = pick_operand();
      if (op == 4'hD || (op == 4'hE && (w8 ? s[7:0] != 8'd0 : s != 16'd0))) lat = w + 1;
      else lat = 2;
      run_op($sformatf("rnd%0d_op%0h", i, op), w8, op, r, s, lat, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
